// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================
// Package : muldiv_pkg
// Brief   : shared op/state encodings and iteration count
// Rev     : 1.0
// ============================================================
package muldiv_pkg;

  localparam int unsigned c_NUM_ITER = 32;
  localparam int unsigned c_CNT_W    = 5;

  localparam logic [1:0] c_OP_MULT  = 2'b00;
  localparam logic [1:0] c_OP_MULTU = 2'b01;
  localparam logic [1:0] c_OP_DIV   = 2'b10;
  localparam logic [1:0] c_OP_DIVU  = 2'b11;

  localparam int unsigned c_ST_W = 2;
  localparam logic [c_ST_W-1:0] c_ST_IDLE = 2'd0;
  localparam logic [c_ST_W-1:0] c_ST_CALC = 2'd1;
  localparam logic [c_ST_W-1:0] c_ST_FIX  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================
// Module : muldiv_step
// Brief  : one shift-add (multiply) or restoring shift-subtract (divide) bit
// Rev    : 1.0
// ============================================================
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_isDiv,
  input  logic [WIDTH-1:0] i_accHi,
  input  logic [WIDTH-1:0] i_accLo,
  input  logic [WIDTH-1:0] i_operand,
  output logic [WIDTH-1:0] o_accHi,
  output logic [WIDTH-1:0] o_accLo
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_mulHi;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH-1:0] w_diff;
  logic             w_fits;

  always_comb begin
    w_sum     = {1'b0, i_accHi} + {1'b0, i_operand};
    w_mulHi   = i_accLo[0] ? w_sum : {1'b0, i_accHi};
    w_shifted = {i_accHi, i_accLo[WIDTH-1]};
    w_fits    = (w_shifted >= {1'b0, i_operand});
    // The true difference is below the divisor, so the low WIDTH bits hold it exactly.
    w_diff    = w_shifted[WIDTH-1:0] - i_operand;
    if (i_isDiv) begin
      o_accHi = w_fits ? w_diff : w_shifted[WIDTH-1:0];
      o_accLo = {i_accLo[WIDTH-2:0], w_fits};
    end else begin
      o_accHi = w_mulHi[WIDTH:1];
      o_accLo = {w_mulHi[0], i_accLo[WIDTH-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================
// Module : muldiv_unit
// Brief  : iterative 32-bit multiply/divide with Hi/Lo result registers
// Rev    : 1.0
// ============================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] InputA,
  input  logic [WIDTH-1:0] InputB,
  input  logic             WrHi,
  input  logic             WrLo,
  input  logic [WIDTH-1:0] WrData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  logic [c_ST_W-1:0]  r_state;
  logic [c_ST_W-1:0]  w_nextState;
  logic [c_CNT_W-1:0] r_iterCnt;
  logic [WIDTH-1:0]   r_accHi, r_accLo, r_operand, r_hi, r_lo;
  logic               r_isDiv, r_negRes, r_negRem, r_done;
  logic               w_accept, w_calc, w_fix, w_directWr, w_lastIter;
  logic               w_isSigned, w_opIsDiv, w_negA, w_negB;
  logic [WIDTH-1:0]   w_magA, w_magB, w_stepHi, w_stepLo, w_fixHi, w_fixLo;
  logic [2*WIDTH-1:0] w_product, w_fixProd;

  assign w_isSigned = (Op == c_OP_MULT) || (Op == c_OP_DIV);
  assign w_opIsDiv  = (Op == c_OP_DIV)  || (Op == c_OP_DIVU);
  assign w_negA     = w_isSigned & InputA[WIDTH-1];
  assign w_negB     = w_isSigned & InputB[WIDTH-1];
  assign w_magA     = w_negA ? -InputA : InputA;
  assign w_magB     = w_negB ? -InputB : InputB;
  assign w_lastIter = (r_iterCnt == c_CNT_W'(c_NUM_ITER - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_ST_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_ST_IDLE: if (Start) w_nextState = c_ST_CALC;
      c_ST_CALC: if (w_lastIter) w_nextState = c_ST_FIX;
      c_ST_FIX:  w_nextState = c_ST_IDLE;
      default:   w_nextState = c_ST_IDLE;
    endcase
  end

  always_comb begin
    Busy       = (r_state != c_ST_IDLE);
    w_accept   = (r_state == c_ST_IDLE) & Start;
    w_calc     = (r_state == c_ST_CALC);
    w_fix      = (r_state == c_ST_FIX);
    w_directWr = (r_state == c_ST_IDLE) & ~Start;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_isDiv   (r_isDiv),
    .i_accHi   (r_accHi),
    .i_accLo   (r_accLo),
    .i_operand (r_operand),
    .o_accHi   (w_stepHi),
    .o_accLo   (w_stepLo)
  );

  // Magnitude results get their signs back here; a zero divisor keeps the all-ones quotient.
  assign w_product = {r_accHi, r_accLo};
  assign w_fixProd = r_negRes ? -w_product : w_product;
  assign w_fixLo   = r_isDiv ? (r_negRes ? -r_accLo : r_accLo) : w_fixProd[WIDTH-1:0];
  assign w_fixHi   = r_isDiv ? (r_negRem ? -r_accHi : r_accHi) : w_fixProd[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iterCnt <= '0;
      r_accHi   <= '0;
      r_accLo   <= '0;
      r_operand <= '0;
      r_isDiv   <= 1'b0;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= w_fix;
      if (w_accept) begin
        r_iterCnt <= '0;
        r_accHi   <= '0;
        r_accLo   <= w_opIsDiv ? w_magA : w_magB;
        r_operand <= w_opIsDiv ? w_magB : w_magA;
        r_isDiv   <= w_opIsDiv;
        r_negRes  <= w_isSigned & (InputA[WIDTH-1] ^ InputB[WIDTH-1])
                     & ~(w_opIsDiv & (InputB == '0));
        r_negRem  <= w_negA;
      end else if (w_calc) begin
        r_iterCnt <= r_iterCnt + 1'b1;
        r_accHi   <= w_stepHi;
        r_accLo   <= w_stepLo;
      end
      if (w_fix) begin
        r_hi <= w_fixHi;
        r_lo <= w_fixLo;
      end else if (w_directWr) begin
        if (WrHi) r_hi <= WrData;
        if (WrLo) r_lo <= WrData;
      end
    end
  end

  assign Done = r_done;
  assign Hi   = r_hi;
  assign Lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================
// Module : tb_muldiv_unit
// Brief  : scoreboard bench for muldiv_unit against an arithmetic reference
// Rev    : 1.0
// ============================================================
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk, rst_n, Start, WrHi, WrLo, Busy, Done;
  logic [1:0]  Op;
  logic [31:0] InputA, InputB, WrData, Hi, Lo;

  typedef struct {
    logic [63:0] res;
    string       tag;
  } exp_t;

  exp_t        scb[$];
  exp_t        monExp;
  int          nCmp = 0;
  int          nErr = 0;
  int          cyc  = 0;
  logic [31:0] lastHi, lastLo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Start  (Start),
    .Op     (Op),
    .InputA (InputA),
    .InputB (InputB),
    .WrHi   (WrHi),
    .WrLo   (WrLo),
    .WrData (WrData),
    .Busy   (Busy),
    .Done   (Done),
    .Hi     (Hi),
    .Lo     (Lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Returns {Hi, Lo} straight from integer arithmetic on the operands.
  function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    int     sa, sb;
    case (op)
      c_OP_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp;
      end
      c_OP_MULTU: return {32'd0, a} * {32'd0, b};
      c_OP_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = $signed(a);
        sb = $signed(b);
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 15));
      4:       return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Called just after a falling edge; returns at the falling edge of cycle 1.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input string tag);
    logic [63:0] r;
    Start  = 1'b1;
    Op     = op;
    InputA = a;
    InputB = b;
    @(posedge clk);
    if (push) begin
      r = refModel(op, a, b);
      scb.push_back('{res: r, tag: tag});
      lastHi = r[63:32];
      lastLo = r[31:0];
    end
    @(negedge clk);
    cyc    = 1;
    Start  = 1'b0;
    Op     = 2'($urandom);
    InputA = $urandom;
    InputB = $urandom;
  endtask

  task automatic waitDone(input string tag);
    bit busyHeld = 1'b1;
    while (Done !== 1'b1 && cyc < 100) begin
      if (Busy !== 1'b1) busyHeld = 1'b0;
      tick();
    end
    check({tag, " done cycle"}, 64'(cyc), 64'd34);
    check({tag, " busy held"}, 64'(busyHeld), 64'd1);
    check({tag, " busy in done cycle"}, 64'(Busy), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && Done === 1'b1) begin
      if (scb.size() == 0) begin
        nCmp++;
        nErr++;
        $display("FAIL unexpected Done: Hi=%h Lo=%h with no result pending", Hi, Lo);
      end else begin
        monExp = scb.pop_front();
        check(monExp.tag, {Hi, Lo}, monExp.res);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    Start  = 1'b0;
    Op     = 2'b00;
    InputA = '0;
    InputB = '0;
    WrHi   = 1'b0;
    WrLo   = 1'b0;
    WrData = '0;
    repeat (3) @(negedge clk);
    check("reset Busy", 64'(Busy), 64'd0);
    check("reset Done", 64'(Done), 64'd0);
    check("reset HiLo", {Hi, Lo}, 64'd0);
    rst_n = 1'b1;

    // Directed cases, issued back-to-back in each Done cycle.
    issue(c_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "multu max");
    waitDone("multu max");
    issue(c_OP_MULT, -32'd3, 32'd7, 1'b1, "mult -3x7");
    waitDone("mult -3x7");
    issue(c_OP_DIV, -32'd7, 32'd2, 1'b1, "div -7/2");
    waitDone("div -7/2");
    issue(c_OP_DIVU, 32'd100, 32'd0, 1'b1, "divu by zero");
    waitDone("divu by zero");
    issue(c_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div overflow");
    waitDone("div overflow");
    issue(c_OP_DIV, -32'd9, 32'd0, 1'b1, "div neg by zero");
    waitDone("div neg by zero");

    // A Start 10 cycles into an operation must be ignored.
    issue(c_OP_DIVU, 32'd1000, 32'd7, 1'b1, "start while busy");
    repeat (9) tick();
    Start  = 1'b1;
    Op     = c_OP_MULT;
    InputA = 32'd5;
    InputB = 32'd9;
    tick();
    Start  = 1'b0;
    waitDone("start while busy");

    // Direct writes while idle, starting in the Done cycle.
    WrHi   = 1'b1;
    WrData = 32'h1234_5678;
    tick();
    WrHi   = 1'b0;
    check("idle WrHi", {Hi, Lo}, {32'h1234_5678, lastLo});
    WrHi   = 1'b1;
    WrLo   = 1'b1;
    WrData = 32'hA5A5_5A5A;
    tick();
    WrHi   = 1'b0;
    WrLo   = 1'b0;
    check("idle WrHi+WrLo", {Hi, Lo}, {32'hA5A5_5A5A, 32'hA5A5_5A5A});

    // The same write while busy is dropped.
    issue(c_OP_MULT, 32'hFFFF_FFFF, 32'd5, 1'b1, "write while busy");
    repeat (4) tick();
    WrHi   = 1'b1;
    WrLo   = 1'b1;
    WrData = 32'h1234_5678;
    tick();
    WrHi   = 1'b0;
    WrLo   = 1'b0;
    check("busy write ignored", {Hi, Lo}, {32'hA5A5_5A5A, 32'hA5A5_5A5A});
    waitDone("write while busy");

    // Reset mid-CALC discards the operation; the next Start is taken on the first edge.
    tick();
    issue(c_OP_DIV, 32'd12345, 32'd17, 1'b0, "aborted");
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("mid-op reset Busy", 64'(Busy), 64'd0);
    check("mid-op reset Done", 64'(Done), 64'd0);
    check("mid-op reset HiLo", {Hi, Lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(c_OP_DIVU, 32'hDEAD_BEEF, 32'd1000, 1'b1, "after reset");
    waitDone("after reset");

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      rop = 2'($urandom);
      ra  = pick();
      rb  = pick();
      issue(rop, ra, rb, 1'b1, $sformatf("rand%0d op%0d %h,%h", i, rop, ra, rb));
      waitDone($sformatf("rand%0d", i));
    end

    repeat (3) tick();
    check("scoreboard drained", 64'(scb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
`default_nettype wire
